// File: rtl/lfsr_hole_placer.sv
// Random game layout: draws MAX_NUM non-overlapping (x,y) positions from a free-running LFSR.
// Optional macro RAND_RETRY_LIMIT_EN: accept an overlapping candidate once the retry counter saturates.
module lfsr_hole_placer #(
    parameter int unsigned MAX_NUM     = 9,
    parameter int unsigned POS_X_RANGE = 288,
    parameter int unsigned POS_Y_RANGE = 148,
    parameter int unsigned COORD_BITS  = 10,
    parameter int unsigned MIN_SEP     = 32,
    parameter logic [15:0] LFSR_INIT   = 16'hACE1
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    output logic [2*COORD_BITS*MAX_NUM-1:0]   o_rand_list,
    output logic                              o_data_ready,
    output logic                              o_busy
);

    localparam int unsigned XW = $clog2(POS_X_RANGE);
    localparam int unsigned YW = $clog2(POS_Y_RANGE);
    localparam int unsigned KW = (MAX_NUM > 1) ? $clog2(MAX_NUM) : 1;
    localparam int unsigned DW = COORD_BITS + 1;

    localparam logic [COORD_BITS-1:0] X_LIM  = COORD_BITS'(POS_X_RANGE);
    localparam logic [COORD_BITS-1:0] Y_LIM  = COORD_BITS'(POS_Y_RANGE);
    localparam logic [DW-1:0]         SEP    = DW'(MIN_SEP);
    localparam logic [KW-1:0]         K_LAST = KW'(MAX_NUM - 1);
    localparam logic [7:0]            RETRY_MAX = 8'hFF;

`ifdef RAND_RETRY_LIMIT_EN
    localparam logic RETRY_CAP_EN = 1'b1;
`else
    localparam logic RETRY_CAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {DRAW, CHECK, STORE, DONE} state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic [KW-1:0]         j;
    logic [7:0]            retry;
    logic [7:0]            retry_inc;
    logic [COORD_BITS-1:0] cand_x;
    logic [COORD_BITS-1:0] cand_y;
    logic [COORD_BITS-1:0] draw_x;
    logic [COORD_BITS-1:0] draw_y;
    logic                  draw_ok;
    logic [COORD_BITS-1:0] ent_x;
    logic [COORD_BITS-1:0] ent_y;
    logic [DW-1:0]         dx;
    logic [DW-1:0]         dy;
    logic                  collide;

    // Seed source: deliberately never reset, so reset length changes the layout.
    logic [15:0] lfsr = LFSR_INIT;

    always_ff @(posedge i_clk) begin
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Candidate extraction, entry lookup and collision test.
    always_comb begin
        draw_x    = COORD_BITS'(lfsr[XW-1:0]);
        draw_y    = COORD_BITS'(lfsr[15 -: YW]);
        draw_ok   = (draw_x < X_LIM) && (draw_y < Y_LIM);
        ent_x     = o_rand_list[COORD_BITS*j +: COORD_BITS];
        ent_y     = o_rand_list[COORD_BITS*(MAX_NUM+j) +: COORD_BITS];
        dx        = (cand_x >= ent_x) ? (DW'(cand_x) - DW'(ent_x)) : (DW'(ent_x) - DW'(cand_x));
        dy        = (cand_y >= ent_y) ? (DW'(cand_y) - DW'(ent_y)) : (DW'(ent_y) - DW'(cand_y));
        collide   = (dx < SEP) && (dy < SEP);
        retry_inc = (retry == RETRY_MAX) ? retry : (retry + 8'd1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= DRAW;
            k            <= '0;
            j            <= '0;
            retry        <= '0;
            cand_x       <= '0;
            cand_y       <= '0;
            o_rand_list  <= '0;
            o_data_ready <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                DRAW: begin
                    o_busy <= 1'b1;
                    cand_x <= draw_x;
                    cand_y <= draw_y;
                    j      <= '0;
                    if (!draw_ok) begin
                        retry <= retry_inc;
                    end else if ((k == '0) || (RETRY_CAP_EN && (retry == RETRY_MAX))) begin
                        state <= STORE;
                    end else begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (collide) begin
                        retry <= retry_inc;
                        state <= DRAW;
                    end else if (j == (k - KW'(1))) begin
                        state <= STORE;
                    end else begin
                        j <= j + KW'(1);
                    end
                end
                STORE: begin
                    o_rand_list[COORD_BITS*k +: COORD_BITS]           <= cand_x;
                    o_rand_list[COORD_BITS*(MAX_NUM+k) +: COORD_BITS] <= cand_y;
                    retry <= '0;
                    if (k == K_LAST) begin
                        state        <= DONE;
                        o_data_ready <= 1'b1;
                        o_busy       <= 1'b0;
                    end else begin
                        k     <= k + KW'(1);
                        state <= DRAW;
                    end
                end
                DONE: begin
                    o_data_ready <= 1'b1;
                    o_busy       <= 1'b0;
                end
                default: state <= DRAW;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_hole_placer.sv
// Scoreboard bench for lfsr_hole_placer: a timing-aware reference model predicts each layout and its ready cycle.
module tb_lfsr_hole_placer;

    localparam int MAX_NUM = 9;
    localparam int CB      = 10;
    localparam int LW      = 2 * CB * MAX_NUM;
    localparam int XR      = 288;
    localparam int YR      = 148;
    localparam int SEP     = 32;
    localparam int BUDGET  = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] rand_list;
    logic          ready;
    logic          busy;

    always #5 clk = ~clk;

    lfsr_hole_placer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_rand_list (rand_list),
        .o_data_ready(ready),
        .o_busy      (busy)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Independent copy of the free-running generator, started from the same power-up value.
    logic [15:0] m_lfsr = 16'hACE1;
    always @(posedge clk) m_lfsr <= lfsr_step(m_lfsr);

    int checks = 0;
    int passes = 0;

    task automatic check(input bit ok, input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Model results: entry coordinates and the post-release clock edge at which each entry is written.
    int m_x[MAX_NUM];
    int m_y[MAX_NUM];
    int m_store[MAX_NUM];

    function automatic void model_gen(input logic [15:0] seed);
        logic [15:0] l;
        int c, k, cx, cy, adv, hit;
        l = seed;
        c = 0;
        k = 0;
        for (int i = 0; i < MAX_NUM; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_store[i] = 0;
        end
        while (k < MAX_NUM && c < BUDGET) begin
            cx  = int'(l[8:0]);
            cy  = int'(l[15:8]);
            hit = -1;
            if (cx >= XR || cy >= YR) begin
                adv = 1;
            end else begin
                for (int j = 0; j < k; j++)
                    if (hit < 0 && iabs(cx - m_x[j]) < SEP && iabs(cy - m_y[j]) < SEP) hit = j;
                if (hit >= 0) begin
                    adv = hit + 2;
                end else begin
                    m_x[k]     = cx;
                    m_y[k]     = cy;
                    m_store[k] = c + 1 + k;
                    adv        = k + 2;
                    k++;
                end
            end
            for (int a = 0; a < adv; a++) l = lfsr_step(l);
            c += adv;
        end
    endfunction

    function automatic logic [LW-1:0] model_list(input int n);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[CB*i +: CB]           = CB'(m_x[i]);
            v[CB*(MAX_NUM+i) +: CB] = CB'(m_y[i]);
        end
        return v;
    endfunction

    function automatic bit range_ok(input logic [LW-1:0] v);
        for (int i = 0; i < MAX_NUM; i++)
            if (int'(v[CB*i +: CB]) >= XR || int'(v[CB*(MAX_NUM+i) +: CB]) >= YR) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit sep_ok(input logic [LW-1:0] v);
        int dx, dy;
        for (int i = 0; i < MAX_NUM; i++)
            for (int j = i + 1; j < MAX_NUM; j++) begin
                dx = iabs(int'(v[CB*i +: CB]) - int'(v[CB*j +: CB]));
                dy = iabs(int'(v[CB*(MAX_NUM+i) +: CB]) - int'(v[CB*(MAX_NUM+j) +: CB]));
                if (dx < SEP && dy < SEP) return 1'b0;
            end
        return 1'b1;
    endfunction

    typedef struct {
        logic [LW-1:0] list;
        int            cycles;
    } exp_t;

    exp_t sb_q[$];

    int edge_cnt = 0;
    always @(posedge clk) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Monitor: on each rising o_data_ready, pop the prediction and compare.
    bit            seen = 1'b0;
    int            done_cnt = 0;
    logic [LW-1:0] last_list = '0;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (ready && !seen) begin
            seen      = 1'b1;
            last_list = rand_list;
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_ready", LW'(1), LW'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check(rand_list == mon_e.list, "list", rand_list, mon_e.list);
                check(edge_cnt == mon_e.cycles, "ready_latency", LW'(edge_cnt), LW'(mon_e.cycles));
            end
            check(!busy, "busy_at_ready", LW'(busy), LW'(0));
            check(range_ok(rand_list), "coord_range", rand_list, LW'(0));
            check(sep_ok(rand_list), "min_separation", rand_list, LW'(0));
            done_cnt++;
        end else if (!ready) begin
            seen = 1'b0;
        end
    end

    task automatic check_reset_state(input string tag);
        check(rand_list == '0, {tag, "_list"}, rand_list, LW'(0));
        check(!ready, {tag, "_ready"}, LW'(ready), LW'(0));
        check(!busy, {tag, "_busy"}, LW'(busy), LW'(0));
    endtask

    task automatic release_run(input bit push);
        exp_t e;
        rst = 1'b0;
        model_gen(m_lfsr);
        if (push) begin
            e.list   = model_list(MAX_NUM);
            e.cycles = m_store[MAX_NUM-1] + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check(busy && !ready, "busy_after_release", LW'({busy, ready}), LW'(2'b10));
    endtask

    task automatic wait_done();
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(done_cnt != start, "ready_timeout", LW'(n), LW'(BUDGET));
    endtask

    logic [LW-1:0] list_a;
    logic [LW-1:0] list_b;
    bit            quiet;

    initial begin
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_state("reset10");
        release_run(1'b1);
        wait_done();
        list_a = last_list;

        // Reset while in DONE clears ready and list at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check(!ready, "reset_in_done_ready", LW'(ready), LW'(0));
        check(rand_list == '0, "reset_in_done_list", rand_list, LW'(0));
        repeat (11) @(negedge clk);
        check_reset_state("reset11");
        release_run(1'b1);
        wait_done();
        list_b = last_list;
        check(list_a != list_b, "seed_depends_on_reset", list_b, list_a);

        @(negedge clk);
        rst   = 1'b1;
        quiet = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (ready || busy) quiet = 1'b0;
        end
        check(quiet, "hold_1000_quiet", LW'(quiet), LW'(1));

        // Abort just after entry 3 is written (k == 4).
        release_run(1'b0);
        repeat (m_store[3]) @(negedge clk);
        check(rand_list == model_list(4), "partial_k4", rand_list, model_list(4));
        rst = 1'b1;
        #1;
        check(rand_list == '0, "abort_list", rand_list, LW'(0));
        check(!ready, "abort_ready", LW'(ready), LW'(0));
        repeat (5) @(negedge clk);
        release_run(1'b1);
        wait_done();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
